// File: rtl/pll_rst_pkg.sv
// Shared definitions for the PLL reset sequencer: state encodings,
// lost-lock counter width and counter sizing helper.
package pll_rst_pkg;

    typedef enum logic [1:0] {
        HOLD      = 2'b00,
        WAIT_LOCK = 2'b01,
        RUN       = 2'b10,
        ILLEGAL   = 2'b11
    } state_t;

    localparam int LOST_W = 8;
    localparam logic [LOST_W-1:0] LOST_MAX = '1;

    // Counter width for a terminal count of n: $clog2(n), never below 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchronizer for a single asynchronous bit.
// All stages clear asynchronously on rst.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift the input through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: holds system reset until the PLL has been locked
// long enough. Lost-lock counter built only when PLL_RESET_SEQ_LOSTCNT_EN is defined.
module pll_reset_seq
    import pll_rst_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              locked,
    output logic              rst_out,
    output logic              ready,
    output logic [1:0]        state,
    output logic [LOST_W-1:0] lost_count
);

    localparam int HW = cnt_w(HOLD_CYCLES);
    localparam int LW = cnt_w(LOCK_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

    state_t          state_q;
    state_t          state_d;
    logic [HW-1:0]   hold_cnt;
    logic [LW-1:0]   lock_cnt;
    logic            locked_sync;
    logic            hold_done;
    logic            lock_done;

    sync_ff #(
        .STAGES (2)
    ) u_sync (
        .clk (clock_in),
        .rst (reset),
        .d   (locked),
        .q   (locked_sync)
    );

    assign hold_done = (hold_cnt == HOLD_LAST);
    assign lock_done = (lock_cnt == LOCK_LAST);

    // State register.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q <= HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the unused encoding falls back to HOLD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HOLD: begin
                if (hold_done) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (locked_sync && lock_done) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!locked_sync) begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = HOLD;
            end
        endcase
    end

    // Hold and lock-qualification counters; both stop at terminal count.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
            lock_cnt <= '0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (hold_done) begin
                        lock_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (!locked_sync) begin
                        lock_cnt <= '0;
                    end else if (!lock_done) begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!locked_sync) begin
                        hold_cnt <= '0;
                    end
                end
                default: begin
                    hold_cnt <= '0;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

    // Registered reset output: released on the edge that enters RUN.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            rst_out <= 1'b1;
        end else begin
            rst_out <= (state_d != RUN);
        end
    end

    // Output decode from the current state.
    always_comb begin
        ready = (state_q == RUN);
        state = state_q;
    end

`ifdef PLL_RESET_SEQ_LOSTCNT_EN
    logic              lost_evt;
    logic [LOST_W-1:0] lost_q;

    assign lost_evt = (state_q == RUN) && !locked_sync;

    // Saturating count of lock losses observed while running.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            lost_q <= '0;
        end else if (lost_evt && (lost_q != LOST_MAX)) begin
            lost_q <= lost_q + 1'b1;
        end
    end

    assign lost_count = lost_q;
`else
    assign lost_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq with HOLD_CYCLES=4, LOCK_CYCLES=8.
// Expected lost_count follows PLL_RESET_SEQ_LOSTCNT_EN.
module tb_pll_reset_seq;
    import pll_rst_pkg::*;

    logic              clock_in;
    logic              reset;
    logic              locked;
    logic              rst_out;
    logic              ready;
    logic [1:0]        state;
    logic [LOST_W-1:0] lost_count;

    typedef struct {
        string       name;
        logic        rst;
        logic        rdy;
        logic [1:0]  st;
        logic [7:0]  lc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    pll_reset_seq #(
        .HOLD_CYCLES (4),
        .LOCK_CYCLES (8)
    ) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .locked     (locked),
        .rst_out    (rst_out),
        .ready      (ready),
        .state      (state),
        .lost_count (lost_count)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    function automatic logic [7:0] lc_exp(input int n);
`ifdef PLL_RESET_SEQ_LOSTCNT_EN
        return (n > 255) ? 8'd255 : 8'(n);
`else
        return (n > 255) ? 8'd0 : 8'd0;
`endif
    endfunction

    task automatic edges(input int n);
        repeat (n) @(posedge clock_in);
        #1;
    endtask

    task automatic expect_v(input string name, input logic r,
                            input logic rd, input state_t st,
                            input int lc);
        exp_t e;
        e.name = name;
        e.rst  = r;
        e.rdy  = rd;
        e.st   = st;
        e.lc   = lc_exp(lc);
        exp_q.push_back(e);
    endtask

    // Monitor: samples the DUT whenever an expectation is queued.
    initial begin
        exp_t e;
        vectors     = 0;
        miscompares = 0;
        forever begin
            wait (exp_q.size() != 0);
            e = exp_q.pop_front();
            vectors++;
            if (rst_out !== e.rst || ready !== e.rdy ||
                state !== e.st || lost_count !== e.lc) begin
                miscompares++;
                $display("FAIL %s: got rst_out=%0b ready=%0b state=%0d lost_count=%0d, want rst_out=%0b ready=%0b state=%0d lost_count=%0d",
                         e.name, rst_out, ready, state, lost_count,
                         e.rst, e.rdy, e.st, e.lc);
            end
        end
    end

    // Stimulus.
    initial begin
        int drain;
        reset  = 1'b1;
        locked = 1'b1;
        #2;
        expect_v("reset_state", 1, 0, HOLD, 0);
        #1 reset = 1'b0;

        // Scenario 1: continuous lock.
        edges(3);
        expect_v("s1_e3_hold", 1, 0, HOLD, 0);
        edges(1);
        expect_v("s1_e4_wait", 1, 0, WAIT_LOCK, 0);
        edges(7);
        expect_v("s1_e11_wait", 1, 0, WAIT_LOCK, 0);
        edges(1);
        expect_v("s1_e12_run", 0, 1, RUN, 0);

        // Scenario 3: one-cycle lock loss in RUN.
        locked = 1'b0;
        edges(1);
        locked = 1'b1;
        expect_v("s3_e1_run", 0, 1, RUN, 0);
        edges(1);
        expect_v("s3_e2_run", 0, 1, RUN, 0);
        edges(1);
        expect_v("s3_e3_hold", 1, 0, HOLD, 1);
        edges(11);
        expect_v("s3_e14_wait", 1, 0, WAIT_LOCK, 1);
        edges(1);
        expect_v("s3_e15_run", 0, 1, RUN, 1);

        // Scenario 5: sub-cycle reset pulse in RUN.
        reset = 1'b1;
        #1;
        expect_v("s5_rst_on", 1, 0, HOLD, 0);
        #1 reset = 1'b0;
        expect_v("s5_rst_off", 1, 0, HOLD, 0);

        // Scenario 2: lock drops for edges 6-7.
        edges(4);
        expect_v("s2_e4_wait", 1, 0, WAIT_LOCK, 0);
        edges(1);
        locked = 1'b0;
        edges(2);
        locked = 1'b1;
        edges(5);
        expect_v("s2_e12_wait", 1, 0, WAIT_LOCK, 0);
        edges(4);
        expect_v("s2_e16_wait", 1, 0, WAIT_LOCK, 0);
        edges(1);
        expect_v("s2_e17_run", 0, 1, RUN, 0);

        // Scenario 4: repeated loss/relock until saturation.
        for (int i = 0; i < 300; i++) begin
            locked = 1'b0;
            edges(1);
            locked = 1'b1;
            edges(1);
            expect_v($sformatf("s4_run_%0d", i), 0, 1, RUN, i);
            edges(1);
            expect_v($sformatf("s4_hold_%0d", i), 1, 0, HOLD, i + 1);
            edges(11);
            expect_v($sformatf("s4_wait_%0d", i), 1, 0, WAIT_LOCK, i + 1);
            edges(1);
            expect_v($sformatf("s4_rerun_%0d", i), 0, 1, RUN, i + 1);
        end
        edges(20);
        expect_v("s4_sat_hold", 0, 1, RUN, 300);

        drain = 0;
        while (exp_q.size() != 0 && drain < 100) begin
            #1;
            drain++;
        end
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16, minimum reset-hold cycles after reset or lock loss (>=1).
REQ-002 SHALL have parameter LOCK_CYCLES, default 1024, consecutive synchronized-lock cycles required before release (>=1).
REQ-003 SHALL have port clock_in  input  1  system clock (PLL clock_out domain).
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port locked  input  1  PLL lock indication, asynchronous to clock_in.
REQ-006 SHALL have port rst_out  output  1  active-high system reset; asserts asynchronously with reset, deasserts synchronously.
REQ-007 SHALL have port ready  output  1  high only in state RUN.
REQ-008 SHALL have port state  output  2  current state encoding.
REQ-009 SHALL have port lost_count  output  8  count of lock-loss events seen in RUN, saturating.

Function
REQ-010 SHALL synchronize locked through a 2-flop synchronizer to locked_sync; both flops reset to 0.
REQ-011 SHALL implement states HOLD=2'b00, WAIT_LOCK=2'b01, RUN=2'b10; 2'b11 SHALL transition to HOLD on the next edge.
REQ-012 HOLD: each edge, if hold_cnt==HOLD_CYCLES-1 go WAIT_LOCK and clear lock_cnt, else hold_cnt+1; locked_sync is ignored.
REQ-013 WAIT_LOCK: each edge with locked_sync=1, if lock_cnt==LOCK_CYCLES-1 go RUN, else lock_cnt+1; locked_sync=0 clears lock_cnt, state unchanged.
REQ-014 RUN: edge with locked_sync=0 SHALL go HOLD, clear hold_cnt, and increment lost_count on the same edge.
REQ-015 rst_out SHALL be registered: 0 exactly when next state is RUN, else 1; ready SHALL equal (state==RUN).
REQ-016 lost_count SHALL saturate at 255 and never wrap.
REQ-017 Latency: locked falling in RUN -> rst_out high after the 3rd rising edge (2 sync + 1 state).
REQ-018 Counter widths SHALL be $clog2 of the respective parameter (minimum 1 bit); no counter SHALL wrap.

Reset
REQ-019 reset=1 SHALL immediately, without a clock edge, force rst_out=1, ready=0, state=HOLD, hold_cnt=0, lock_cnt=0, sync flops=0, lost_count=0.
REQ-020 Reset asserted mid-operation SHALL abort any state; after release, sequencing SHALL restart from HOLD.

Configuration
REQ-021 Macro PLL_RESET_SEQ_LOSTCNT_EN defined: lost_count SHALL be implemented per REQ-014/REQ-016.
REQ-022 Macro undefined: lost_count SHALL be constant 8'd0, no counter register SHALL be built, and all other behaviour SHALL be unchanged.

Structure
REQ-023 Shared package pll_rst_pkg SHALL hold the state encodings (HOLD, WAIT_LOCK, RUN) and the lost_count width constant (8).
REQ-024 The synchronizer SHALL be a separate sub-module sync_ff (parameter STAGES, default 2, async active-high reset), instantiated once.

Verification (HOLD_CYCLES=4, LOCK_CYCLES=8)
REQ-025 Scenario 1: locked=1 throughout, reset released before edge 1 -> state WAIT_LOCK after edge 4; rst_out=0 and ready=1 after edge 12.
REQ-026 Scenario 2: as scenario 1, but locked low for edges 6-7 -> lock_cnt clears; rst_out release is delayed past edge 12, occurring after the 8th consecutive locked_sync=1 edge.
REQ-027 Scenario 3: in RUN, locked low for 1 cycle -> rst_out=1 after the 3rd edge, state=HOLD, lost_count=1; rst_out=0 again after a further 4+8 edges.
REQ-028 Scenario 4: 300 lock-loss/relock cycles -> lost_count=255 and remains 255.
REQ-029 Scenario 5: reset pulse (shorter than one clock period) in RUN, no clock edge -> rst_out=1, ready=0, lost_count=0 immediately.
REQ-030 Scenario 6: PLL_RESET_SEQ_LOSTCNT_EN undefined, scenario 3 repeated -> lost_count=0, all other responses identical.
